bexkat1_intcalc: RTL and testbench
==================================

Name: bexkat1_intcalc

Overview:
- Multicycle integer execution unit for the bexkat1 CPU.
- It is the responder to the control unit's T_INT/T_INTU requests: the control unit issues a function code and two operands, and this block returns the result with a start/done handshake.
- Covers all intfunc_t codes: iterative shift-add multiply, restoring divide, and single-cycle unary ops.
- The result feeds the MDR_INT path; the MULX/MULUX high word supports REG_WRITE_DW.

Parameters:
- WIDTH, 32, operand/result width. Iteration count equals WIDTH. Must be even and >= 16.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; synchronous, active-high.
- start_i  in  1  request strobe. Sampled only in IDLE.
- func_i  in  4  intfunc_t function code. Latched on accept.
- in1_i  in  WIDTH  operand A: dividend, multiplicand, or unary source. Latched on accept.
- in2_i  in  WIDTH  operand B (B or SVAL, selected externally by int2_t). Latched on accept.
- busy_o  out  1  high from the cycle after accept until done.
- done_o  out  1  one-cycle pulse; result valid.
- out_o  out  WIDTH  result: low product, quotient, remainder, or unary result.
- outx_o  out  WIDTH  high product word (MUL family); 0 otherwise.
- div0_o  out  1  set with done when DIV/MOD/DIVU/MODU had in2 == 0.

Behaviour:
- Reset: the synchronous rst_i forces
  - state = IDLE;
  - busy_o = 0, done_o = 0, div0_o = 0;
  - out_o = 0, outx_o = 0.
  Reset mid-operation abandons the operation; no done pulse is produced.
- States (intstate_t): IDLE, MUL, DIV, FIX, DONE.
- IDLE with start_i = 1: latch func/in1/in2 and branch on the function:
  - Unary/EXT codes or illegal codes 12-15: compute immediately, go to DONE. done_o is high the next cycle (latency 1).
  - MUL, MULU, MULX, MULUX: load magnitudes (signed codes only), count = WIDTH, go to MUL.
  - DIV, MOD, DIVU, MODU with in2 != 0: load magnitudes, count = WIDTH, go to DIV.
  - DIV family with in2 == 0: go to DONE with quotient = all-ones, remainder = in1, div0_o = 1 (latency 1).
- MUL: one shift-add step per cycle over a 2*WIDTH accumulator. Decrement count; at count == 1, go to FIX.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). At count == 1, go to FIX.
- FIX, one cycle, applies signs:
  - Product is negated (2*WIDTH wide) if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
  - The selected word goes to out_o; the product high word goes to outx_o. Then go to DONE.
- DONE: done_o = 1 for exactly one cycle, busy_o = 0, then return to IDLE.
- Latency for MUL/DIV families: done_o is high exactly WIDTH+2 cycles after the accept edge (34 for WIDTH = 32).
- Unary results (source in1):
  - EXT: sign-extend bits [15:0].
  - EXTB: sign-extend bits [7:0].
  - COM: bitwise not.
  - NEG: two's complement negation; NEG of 0x80000000 gives 0x80000000.
  - Illegal codes: out_o = 0.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000; MOD of the same gives 0. Neither trap nor flag.
- Unsigned codes never negate.
- MUL/MULU return the low word; outx_o also carries the high word.
- Output holding:
  - out_o, outx_o and div0_o hold their values until the next accept.
  - div0_o clears on accept.
  - start_i while busy is ignored, with no queueing.
  - The control unit must hold the operands only in the accept cycle.

Decomposition:
- bexkat1Def package: add intstate_t enum {INT_IDLE, INT_MUL, INT_DIV, INT_FIX, INT_DONE}. Reuse the existing intfunc_t unchanged.
- Sign/magnitude helpers are local functions.
- One natural sub-module: bexkat1_intcalc_step. It is the combinational one-iteration datapath (shift-add or restore-subtract selected by a mode bit) that the FSM instantiates once.

Test Plan:
- MULX with in1 = 0xFFFFFFFE (-2), in2 = 0x00000003 -> out_o = 0xFFFFFFFA, outx_o = 0xFFFFFFFF, done_o exactly 34 cycles after accept, busy_o high cycles 1-33.
- MULUX with 0xFFFFFFFF × 0xFFFFFFFF -> out_o = 0x00000001, outx_o = 0xFFFFFFFE.
- DIV -7 / 2 -> out_o = 0xFFFFFFFD (-3). MOD -7 % 2 -> out_o = 0xFFFFFFFF (-1). DIVU 100 / 7 -> 14. MODU 100 % 7 -> 2.
- DIVU 5 / 0 -> out_o = 0xFFFFFFFF, div0_o = 1, done_o 1 cycle after accept. MODU 5 / 0 -> out_o = 5. DIV 0x80000000 / -1 -> 0x80000000, div0_o = 0.
- EXTB 0x00000080 -> 0xFFFFFF80; EXT 0x00017FFF -> 0x00007FFF; COM 0 -> 0xFFFFFFFF; NEG 1 -> 0xFFFFFFFF. Each gives done_o after 1 cycle. Code 13 -> out_o = 0.
- Start a DIV, assert rst_i at iteration 10 -> next cycle busy_o = 0 and out_o = 0, with no done pulse. Start pulses during busy are ignored. Start asserted in the DONE cycle is accepted only once IDLE is re-entered.

Source files
------------

// File: rtl/bexkat1_intcalc_pkg.sv
// Shared types for the bexkat1 integer execution unit: function codes,
// FSM states and small decode helpers.
package bexkat1_intcalc_pkg;

  typedef enum logic [3:0] {
    I_MUL   = 4'd0,
    I_DIV   = 4'd1,
    I_MOD   = 4'd2,
    I_MULU  = 4'd3,
    I_DIVU  = 4'd4,
    I_MODU  = 4'd5,
    I_MULX  = 4'd6,
    I_MULUX = 4'd7,
    I_EXT   = 4'd8,
    I_EXTB  = 4'd9,
    I_COM   = 4'd10,
    I_NEG   = 4'd11
  } intfunc_t;

  typedef enum logic [2:0] {
    INT_IDLE = 3'd0,
    INT_MUL  = 3'd1,
    INT_DIV  = 3'd2,
    INT_FIX  = 3'd3,
    INT_DONE = 3'd4
  } intstate_t;

  function automatic logic is_mul(input logic [3:0] f);
    return (f == I_MUL) || (f == I_MULU) || (f == I_MULX) || (f == I_MULUX);
  endfunction

  function automatic logic is_divmod(input logic [3:0] f);
    return (f == I_DIV) || (f == I_MOD) || (f == I_DIVU) || (f == I_MODU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] f);
    return (f == I_MUL) || (f == I_MULX) || (f == I_DIV) || (f == I_MOD);
  endfunction

endpackage

// File: rtl/bexkat1_intcalc_if.sv
// Request/response bundle between the control unit (master) and the
// integer execution unit (slave).
interface bexkat1_intcalc_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [3:0]       func_i;
  logic [WIDTH-1:0] in1_i;
  logic [WIDTH-1:0] in2_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] out_o;
  logic [WIDTH-1:0] outx_o;
  logic             div0_o;

  modport master (
    output start_i, func_i, in1_i, in2_i,
    input  busy_o, done_o, out_o, outx_o, div0_o
  );

  modport slave (
    input  start_i, func_i, in1_i, in2_i,
    output busy_o, done_o, out_o, outx_o, div0_o
  );
endinterface

// File: rtl/bexkat1_intcalc_step.sv
// One iteration of the multicycle datapath: shift-add multiply step or
// restoring divide step over a {hi, lo} accumulator.
module bexkat1_intcalc_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_mode,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] shifted_s;

  // Multiply adds into hi then shifts right; divide shifts left and trial-subtracts.
  always_comb begin
    sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    shifted_s = acc[2*WIDTH-1:WIDTH-1];
    if (!div_mode) begin
      acc_next = {sum_s, acc[WIDTH-1:1]};
    end else if (shifted_s >= {1'b0, operand}) begin
      acc_next = {shifted_s[WIDTH-1:0] - operand, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {shifted_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/bexkat1_intcalc.sv
// Multicycle integer execution unit: iterative multiply/divide on magnitudes
// with a final sign-fix cycle, plus single-cycle unary operations.
module bexkat1_intcalc
  import bexkat1_intcalc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  bexkat1_intcalc_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? negate(v) : v;
  endfunction

  intstate_t          state_r;
  logic [3:0]         func_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   opb_r;
  logic               neg_r, dsign_r;
  logic               busy_r, done_r, div0_r;
  logic [WIDTH-1:0]   out_r, outx_r;

  logic               sgn_s;
  logic [WIDTH-1:0]   mag_a_s, mag_b_s, unary_s;
  logic [2*WIDTH-1:0] acc_next_s, prod_s;
  logic [WIDTH-1:0]   fix_out_s, fix_outx_s;

  bexkat1_intcalc_step #(.WIDTH(WIDTH)) u_step (
    .div_mode (state_r == INT_DIV),
    .acc      (acc_r),
    .operand  (opb_r),
    .acc_next (acc_next_s)
  );

  // Accept-cycle decode: operand magnitudes and the immediate unary result.
  always_comb begin
    sgn_s   = is_signed_op(bus.func_i);
    mag_a_s = magnitude(bus.in1_i, sgn_s);
    mag_b_s = magnitude(bus.in2_i, sgn_s);
    case (bus.func_i)
      I_EXT:   unary_s = {{(WIDTH-16){bus.in1_i[15]}}, bus.in1_i[15:0]};
      I_EXTB:  unary_s = {{(WIDTH-8){bus.in1_i[7]}}, bus.in1_i[7:0]};
      I_COM:   unary_s = ~bus.in1_i;
      I_NEG:   unary_s = negate(bus.in1_i);
      default: unary_s = {WIDTH{1'b0}};
    endcase
  end

  // Sign fix: negate product/quotient on differing signs, remainder follows the dividend.
  always_comb begin
    prod_s = neg_r ? negate_wide(acc_r) : acc_r;
    if (is_mul(func_r)) begin
      fix_out_s  = prod_s[WIDTH-1:0];
      fix_outx_s = prod_s[2*WIDTH-1:WIDTH];
    end else if ((func_r == I_DIV) || (func_r == I_DIVU)) begin
      fix_out_s  = neg_r ? negate(acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
      fix_outx_s = {WIDTH{1'b0}};
    end else if ((func_r == I_MOD) || (func_r == I_MODU)) begin
      fix_out_s  = dsign_r ? negate(acc_r[2*WIDTH-1:WIDTH]) : acc_r[2*WIDTH-1:WIDTH];
      fix_outx_s = {WIDTH{1'b0}};
    end else begin
      fix_out_s  = {WIDTH{1'b0}};
      fix_outx_s = {WIDTH{1'b0}};
    end
  end

  // Control FSM with registered outputs; reset abandons any operation in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= INT_IDLE;
      func_r  <= 4'd0;
      count_r <= {CW{1'b0}};
      acc_r   <= {(2*WIDTH){1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      neg_r   <= 1'b0;
      dsign_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      div0_r  <= 1'b0;
      out_r   <= {WIDTH{1'b0}};
      outx_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        INT_IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
          if (bus.start_i) begin
            func_r  <= bus.func_i;
            div0_r  <= 1'b0;
            outx_r  <= {WIDTH{1'b0}};
            acc_r   <= {{WIDTH{1'b0}}, mag_a_s};
            opb_r   <= mag_b_s;
            neg_r   <= sgn_s & (bus.in1_i[WIDTH-1] ^ bus.in2_i[WIDTH-1]);
            dsign_r <= sgn_s & bus.in1_i[WIDTH-1];
            count_r <= CNT_LOAD;
            if (is_mul(bus.func_i)) begin
              state_r <= INT_MUL;
            end else if (is_divmod(bus.func_i)) begin
              if (bus.in2_i == {WIDTH{1'b0}}) begin
                div0_r  <= 1'b1;
                out_r   <= ((bus.func_i == I_DIV) || (bus.func_i == I_DIVU)) ?
                           {WIDTH{1'b1}} : bus.in1_i;
                state_r <= INT_DONE;
              end else begin
                state_r <= INT_DIV;
              end
            end else begin
              out_r   <= unary_s;
              state_r <= INT_DONE;
            end
          end
        end
        INT_MUL, INT_DIV: begin
          busy_r  <= 1'b1;
          acc_r   <= acc_next_s;
          count_r <= count_r - CNT_ONE;
          if (count_r == CNT_ONE) begin
            state_r <= INT_FIX;
          end
        end
        INT_FIX: begin
          busy_r  <= 1'b1;
          out_r   <= fix_out_s;
          outx_r  <= fix_outx_s;
          state_r <= INT_DONE;
        end
        INT_DONE: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
          state_r <= INT_IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= INT_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o = busy_r;
  assign bus.done_o = done_r;
  assign bus.div0_o = div0_r;
  assign bus.out_o  = out_r;
  assign bus.outx_o = outx_r;

endmodule

// File: tb/tb_bexkat1_intcalc.sv
// Scoreboard bench for bexkat1_intcalc: expected results are queued at issue
// and compared, with latency and busy occupancy, when done_o pulses.
module tb_bexkat1_intcalc;
  import bexkat1_intcalc_pkg::*;

  typedef struct packed {
    logic [31:0] out;
    logic [31:0] outx;
    logic        div0;
    logic [7:0]  lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  bexkat1_intcalc_if #(.WIDTH(32)) bus ();

  bexkat1_intcalc #(.WIDTH(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] o, input logic [31:0] ox, input logic d0, input logic [7:0] lat);
    exp_t e;
    e.out = o; e.outx = ox; e.div0 = d0; e.lat = lat;
    return e;
  endfunction

  // Reference model built on 64-bit host arithmetic.
  function automatic exp_t model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic signed [63:0] sa, sbv, r;
    logic [63:0] ua, ub, u;
    sa  = {{32{a[31]}}, a};
    sbv = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    e   = mk(32'h0, 32'h0, 1'b0, 8'd34);
    case (f)
      I_MUL, I_MULX: begin
        r = sa * sbv; e.out = r[31:0]; e.outx = r[63:32];
      end
      I_MULU, I_MULUX: begin
        u = ua * ub; e.out = u[31:0]; e.outx = u[63:32];
      end
      I_DIV, I_MOD, I_DIVU, I_MODU: begin
        if (b == 32'h0) begin
          e.div0 = 1'b1;
          e.lat  = 8'd1;
          e.out  = ((f == I_DIV) || (f == I_DIVU)) ? 32'hFFFFFFFF : a;
        end else if (f == I_DIV) begin
          r = sa / sbv; e.out = r[31:0];
        end else if (f == I_MOD) begin
          r = sa % sbv; e.out = r[31:0];
        end else if (f == I_DIVU) begin
          u = ua / ub; e.out = u[31:0];
        end else begin
          u = ua % ub; e.out = u[31:0];
        end
      end
      I_EXT:   begin e.out = {{16{a[15]}}, a[15:0]}; e.lat = 8'd1; end
      I_EXTB:  begin e.out = {{24{a[7]}}, a[7:0]};   e.lat = 8'd1; end
      I_COM:   begin e.out = ~a;                     e.lat = 8'd1; end
      I_NEG:   begin e.out = 32'h0 - a;              e.lat = 8'd1; end
      default: begin e.out = 32'h0;                  e.lat = 8'd1; end
    endcase
    return e;
  endfunction

  // Called #1 after the accept edge; waits for done and scores the result.
  task automatic wait_done(input string tag, input bit poke);
    int   cyc = 0;
    int   busy_n = 0;
    exp_t e;
    while (bus.done_o !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (poke) begin
        bus.start_i = (cyc == 5);
        bus.func_i  = I_COM;
        bus.in1_i   = $urandom;
      end
      if (bus.done_o !== 1'b1 && bus.busy_o === 1'b1) busy_n++;
    end
    bus.start_i = 1'b0;
    e = exp_q.pop_front();
    check_eq({tag, "_done"}, 64'(bus.done_o), 64'd1);
    check_eq({tag, "_lat"},  64'(cyc), 64'(e.lat));
    check_eq({tag, "_busy"}, 64'(busy_n), 64'(e.lat) - 64'd1);
    check_eq({tag, "_out"},  64'(bus.out_o), 64'(e.out));
    check_eq({tag, "_outx"}, 64'(bus.outx_o), 64'(e.outx));
    check_eq({tag, "_div0"}, 64'(bus.div0_o), 64'(e.div0));
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, 64'(bus.done_o), 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e, input bit poke);
    exp_q.push_back(e);
    bus.start_i = 1'b1;
    bus.func_i  = f;
    bus.in1_i   = a;
    bus.in2_i   = b;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.func_i  = 4'($urandom_range(0, 15));
    bus.in1_i   = $urandom;
    bus.in2_i   = $urandom;
    wait_done(tag, poke);
  endtask

  initial begin
    int   cyc;
    int   done_n;
    exp_t e;
    logic [3:0]  rf;
    logic [31:0] ra, rb;

    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.func_i  = 4'd0;
    bus.in1_i   = 32'h0;
    bus.in2_i   = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("rst_busy", 64'(bus.busy_o), 64'd0);
    check_eq("rst_done", 64'(bus.done_o), 64'd0);
    check_eq("rst_out",  64'(bus.out_o),  64'd0);
    check_eq("rst_outx", 64'(bus.outx_o), 64'd0);
    check_eq("rst_div0", 64'(bus.div0_o), 64'd0);

    run_op("mulx",   I_MULX,  32'hFFFFFFFE, 32'h00000003, mk(32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 8'd34), 1'b0);
    run_op("mulux",  I_MULUX, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(32'h00000001, 32'hFFFFFFFE, 1'b0, 8'd34), 1'b0);
    run_op("mul_pk", I_MUL,   32'h00000007, 32'hFFFFFFFD, mk(32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 8'd34), 1'b1);
    run_op("div",    I_DIV,   32'hFFFFFFF9, 32'h00000002, mk(32'hFFFFFFFD, 32'h0, 1'b0, 8'd34), 1'b0);
    run_op("mod",    I_MOD,   32'hFFFFFFF9, 32'h00000002, mk(32'hFFFFFFFF, 32'h0, 1'b0, 8'd34), 1'b0);
    run_op("divu",   I_DIVU,  32'd100, 32'd7, mk(32'd14, 32'h0, 1'b0, 8'd34), 1'b0);
    run_op("modu",   I_MODU,  32'd100, 32'd7, mk(32'd2,  32'h0, 1'b0, 8'd34), 1'b0);
    run_op("divu0",  I_DIVU,  32'd5, 32'd0, mk(32'hFFFFFFFF, 32'h0, 1'b1, 8'd1), 1'b0);
    run_op("modu0",  I_MODU,  32'd5, 32'd0, mk(32'd5, 32'h0, 1'b1, 8'd1), 1'b0);
    run_op("divovf", I_DIV,   32'h80000000, 32'hFFFFFFFF, mk(32'h80000000, 32'h0, 1'b0, 8'd34), 1'b0);
    run_op("modovf", I_MOD,   32'h80000000, 32'hFFFFFFFF, mk(32'h00000000, 32'h0, 1'b0, 8'd34), 1'b0);
    run_op("extb",   I_EXTB,  32'h00000080, 32'h0, mk(32'hFFFFFF80, 32'h0, 1'b0, 8'd1), 1'b0);
    run_op("ext",    I_EXT,   32'h00017FFF, 32'h0, mk(32'h00007FFF, 32'h0, 1'b0, 8'd1), 1'b0);
    run_op("com",    I_COM,   32'h00000000, 32'h0, mk(32'hFFFFFFFF, 32'h0, 1'b0, 8'd1), 1'b0);
    run_op("neg",    I_NEG,   32'h00000001, 32'h0, mk(32'hFFFFFFFF, 32'h0, 1'b0, 8'd1), 1'b0);
    run_op("negmin", I_NEG,   32'h80000000, 32'h0, mk(32'h80000000, 32'h0, 1'b0, 8'd1), 1'b0);
    run_op("ill13",  4'd13,   32'h12345678, 32'h9, mk(32'h00000000, 32'h0, 1'b0, 8'd1), 1'b0);

    // Start raised in the DONE-state cycle must wait until IDLE is re-entered.
    exp_q.push_back(model(I_MULU, 32'd1234, 32'd5678));
    bus.start_i = 1'b1; bus.func_i = I_MULU; bus.in1_i = 32'd1234; bus.in2_i = 32'd5678;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    cyc = 0;
    while (bus.done_o !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 33) begin
        exp_q.push_back(mk(32'hEDCBA987, 32'h0, 1'b0, 8'd2));
        bus.start_i = 1'b1; bus.func_i = I_COM; bus.in1_i = 32'h12345678;
      end
    end
    e = exp_q.pop_front();
    check_eq("dc_lat", 64'(cyc), 64'(e.lat));
    check_eq("dc_out", 64'(bus.out_o), 64'(e.out));
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    check_eq("dc_gap", 64'(bus.done_o), 64'd0);
    @(posedge clk); #1;
    e = exp_q.pop_front();
    check_eq("dc_done2", 64'(bus.done_o), 64'd1);
    check_eq("dc_out2",  64'(bus.out_o), 64'(e.out));

    // Reset in the middle of a divide: no done pulse, outputs cleared.
    bus.start_i = 1'b1; bus.func_i = I_DIV; bus.in1_i = 32'd1000; bus.in2_i = 32'd3;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_busy", 64'(bus.busy_o), 64'd0);
    check_eq("abort_out",  64'(bus.out_o),  64'd0);
    rst = 1'b0;
    done_n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done_o === 1'b1) done_n++;
    end
    check_eq("abort_nodone", 64'(done_n), 64'd0);

    for (int i = 0; i < 12; i++) begin
      rf = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op($sformatf("rnd%0d", i), rf, ra, rb, model(rf, ra, rb), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
